// File: rtl/e203_exu_fpu_fmis_mvsgn.sv
// FPU move / sign-injection unit: FMV.X.W, FMV.W.X, FSGNJ/FSGNJN/FSGNJX.S with NaN-boxing.
// Latency: 1 cycle from issue acceptance to o_valid (registered result, no bypass).
// Backpressure: 2-entry skid buffer; i_ready = (count != 2), independent of o_ready.
module e203_exu_fpu_fmis_mvsgn #(
  parameter int FLEN   = 32,
  parameter int ITAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [2:0]        i_op,
  input  logic [FLEN-1:0]   i_rs1,
  input  logic [FLEN-1:0]   i_rs2,
  input  logic [ITAG_W-1:0] i_itag,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [FLEN-1:0]   o_wbck_wdat,
  output logic              o_wbck_ifp,
  output logic [ITAG_W-1:0] o_itag,
  output logic              o_ill
);

  localparam logic [2:0] OP_FMV_X_W = 3'd0;
  localparam logic [2:0] OP_FMV_W_X = 3'd1;
  localparam logic [2:0] OP_FSGNJ   = 3'd2;
  localparam logic [2:0] OP_FSGNJN  = 3'd3;
  localparam logic [2:0] OP_FSGNJX  = 3'd4;

  localparam logic [31:0]     CANON_NAN = 32'h7FC0_0000;
  // Low 32 bits set: OR-ing it in leaves only the box bits to test (all ones for FLEN=32).
  localparam logic [FLEN-1:0] LO_MASK   = FLEN'({32{1'b1}});

  typedef struct packed {
    logic [FLEN-1:0]   data;
    logic              ifp;
    logic              ill;
    logic [ITAG_W-1:0] itag;
  } ent_t;

  logic [31:0] u1;
  logic        u2_sgn;
  ent_t        new_ent;
  ent_t        mem [2];
  ent_t        head;
  logic [1:0]  cnt;
  logic        rptr;
  logic        wptr;
  logic        push;
  logic        pop;

  // Unbox operands; an improperly boxed single reads as the canonical NaN (sign 0).
  always_comb begin
    u1     = (&(i_rs1 | LO_MASK)) ? i_rs1[31:0] : CANON_NAN;
    u2_sgn = (&(i_rs2 | LO_MASK)) ? i_rs2[31]   : CANON_NAN[31];
  end

  // Per-op result formation; FP results are boxed by presetting the upper bits to ones.
  always_comb begin
    new_ent      = '0;
    new_ent.itag = i_itag;
    case (i_op)
      OP_FMV_X_W: begin
        new_ent.data       = {FLEN{i_rs1[31]}};
        new_ent.data[31:0] = i_rs1[31:0];
      end
      OP_FMV_W_X: begin
        new_ent.data       = '1;
        new_ent.data[31:0] = i_rs1[31:0];
        new_ent.ifp        = 1'b1;
      end
      OP_FSGNJ: begin
        new_ent.data       = '1;
        new_ent.data[31:0] = {u2_sgn, u1[30:0]};
        new_ent.ifp        = 1'b1;
      end
      OP_FSGNJN: begin
        new_ent.data       = '1;
        new_ent.data[31:0] = {~u2_sgn, u1[30:0]};
        new_ent.ifp        = 1'b1;
      end
      OP_FSGNJX: begin
        new_ent.data       = '1;
        new_ent.data[31:0] = {u1[31] ^ u2_sgn, u1[30:0]};
        new_ent.ifp        = 1'b1;
      end
      default: begin
        new_ent.ill = 1'b1;
      end
    endcase
  end

  assign i_ready = (cnt != 2'd2);
  assign o_valid = (cnt != 2'd0);
  assign push    = i_valid & i_ready & ~i_flush;
  assign pop     = o_valid & o_ready;

  // Two-entry result buffer; flush empties it and drops any same-cycle input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 2'd0;
      rptr   <= 1'b0;
      wptr   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (i_flush) begin
      cnt  <= 2'd0;
      rptr <= 1'b0;
      wptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= new_ent;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Head entry drives the writeback port straight from flops.
  always_comb begin
    head        = mem[rptr];
    o_wbck_wdat = head.data;
    o_wbck_ifp  = head.ifp;
    o_ill       = head.ill;
    o_itag      = head.itag;
  end

endmodule

// File: tb/tb_e203_exu_fpu_fmis_mvsgn.sv
// Testbench for e203_exu_fpu_fmis_mvsgn: FLEN=32 and FLEN=64 instances share control inputs.
// Latency: results checked 1 cycle after acceptance.
// Backpressure: o_ready driven by directed sequences.
module tb_e203_exu_fpu_fmis_mvsgn;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid, i_flush, o_ready;
  logic [2:0]  i_op;
  logic [63:0] rs1, rs2;
  logic [3:0]  i_itag;

  logic        rdy32, vld32, ifp32, ill32;
  logic [31:0] d32;
  logic [3:0]  tag32;
  logic        rdy64, vld64, ifp64, ill64;
  logic [63:0] d64;
  logic [3:0]  tag64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  e203_exu_fpu_fmis_mvsgn #(.FLEN(32), .ITAG_W(4)) u32 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(rdy32), .i_op(i_op),
    .i_rs1(rs1[31:0]), .i_rs2(rs2[31:0]), .i_itag(i_itag), .i_flush(i_flush),
    .o_valid(vld32), .o_ready(o_ready), .o_wbck_wdat(d32), .o_wbck_ifp(ifp32),
    .o_itag(tag32), .o_ill(ill32)
  );

  e203_exu_fpu_fmis_mvsgn #(.FLEN(64), .ITAG_W(4)) u64 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(rdy64), .i_op(i_op),
    .i_rs1(rs1), .i_rs2(rs2), .i_itag(i_itag), .i_flush(i_flush),
    .o_valid(vld64), .o_ready(o_ready), .o_wbck_wdat(d64), .o_wbck_ifp(ifp64),
    .o_itag(tag64), .o_ill(ill64)
  );

  typedef struct {
    logic [2:0]  op;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [3:0]  tag;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        ifp;
    logic        ill;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] tag);
    i_valid = 1'b1;
    i_op    = op;
    rs1     = a;
    rs2     = b;
    i_itag  = tag;
  endtask

  initial begin
    vt[0]  = '{3'd0, 64'h0000_0000_8000_0001, 64'h0, 4'd1, 32'h8000_0001, 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b0};
    vt[1]  = '{3'd1, 64'h0000_0000_3F80_0000, 64'h0, 4'd2, 32'h3F80_0000, 64'hFFFF_FFFF_3F80_0000, 1'b1, 1'b0};
    vt[2]  = '{3'd2, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_8000_0000, 4'd3, 32'hBF80_0000, 64'hFFFF_FFFF_FFC0_0000, 1'b1, 1'b0};
    vt[3]  = '{3'd2, 64'hFFFF_FFFF_BF80_0000, 64'hFFFF_FFFF_8000_0000, 4'd4, 32'hBF80_0000, 64'hFFFF_FFFF_BF80_0000, 1'b1, 1'b0};
    vt[4]  = '{3'd3, 64'hFFFF_FFFF_BF80_0000, 64'hFFFF_FFFF_8000_0000, 4'd5, 32'h3F80_0000, 64'hFFFF_FFFF_3F80_0000, 1'b1, 1'b0};
    vt[5]  = '{3'd4, 64'hFFFF_FFFF_BF80_0000, 64'hFFFF_FFFF_8000_0000, 4'd6, 32'h3F80_0000, 64'hFFFF_FFFF_3F80_0000, 1'b1, 1'b0};
    vt[6]  = '{3'd4, 64'hFFFF_FFFF_3F80_0000, 64'h0000_0001_FFFF_FFFF, 4'd7, 32'hBF80_0000, 64'hFFFF_FFFF_3F80_0000, 1'b1, 1'b0};
    vt[7]  = '{3'd3, 64'h0000_0000_4000_0000, 64'hFFFF_FFFF_0000_0000, 4'd8, 32'hC000_0000, 64'hFFFF_FFFF_FFC0_0000, 1'b1, 1'b0};
    vt[8]  = '{3'd5, 64'hFFFF_FFFF_1234_5678, 64'h1, 4'd9, 32'h0, 64'h0, 1'b0, 1'b1};
    vt[9]  = '{3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd15, 32'h0, 64'h0, 1'b0, 1'b1};
    vt[10] = '{3'd0, 64'hFFFF_FFFF_7FFF_FFFF, 64'h0, 4'd10, 32'h7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, 1'b0, 1'b0};

    i_valid = 1'b0;
    i_flush = 1'b0;
    o_ready = 1'b1;
    i_op    = 3'd0;
    rs1     = '0;
    rs2     = '0;
    i_itag  = '0;

    // Reset state
    #12;
    chk("rst o_valid32", {63'd0, vld32}, 64'd0);
    chk("rst i_ready32", {63'd0, rdy32}, 64'd1);
    chk("rst data32", {32'd0, d32}, 64'd0);
    chk("rst data64", d64, 64'd0);
    chk("rst itag64", {60'd0, tag64}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors, o_ready held high
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].tag);
      chk($sformatf("v%0d i_ready", i), {63'd0, rdy32}, 64'd1);
      tick();
      i_valid = 1'b0;
      chk($sformatf("v%0d vld32", i), {63'd0, vld32}, 64'd1);
      chk($sformatf("v%0d d32", i), {32'd0, d32}, {32'd0, vt[i].e32});
      chk($sformatf("v%0d d64", i), d64, vt[i].e64);
      chk($sformatf("v%0d ifp32", i), {63'd0, ifp32}, {63'd0, vt[i].ifp});
      chk($sformatf("v%0d ifp64", i), {63'd0, ifp64}, {63'd0, vt[i].ifp});
      chk($sformatf("v%0d ill64", i), {63'd0, ill64}, {63'd0, vt[i].ill});
      chk($sformatf("v%0d itag32", i), {60'd0, tag32}, {60'd0, vt[i].tag});
    end
    tick();
    chk("drain o_valid", {63'd0, vld32}, 64'd0);

    // Back-to-back throughput
    for (int k = 0; k < 4; k++) begin
      drive(3'd1, 64'(k), 64'h0, 4'(10 + k));
      tick();
      chk($sformatf("thru%0d itag", k), {60'd0, tag64}, 64'(10 + k));
      chk($sformatf("thru%0d i_ready", k), {63'd0, rdy64}, 64'd1);
    end
    i_valid = 1'b0;
    tick();
    chk("thru drain", {63'd0, vld64}, 64'd0);

    // Backpressure: absorb two, hold the third, drain in order
    o_ready = 1'b0;
    drive(3'd1, 64'h11, 64'h0, 4'd1);
    tick();
    chk("bp1 i_ready", {63'd0, rdy32}, 64'd1);
    chk("bp1 itag", {60'd0, tag32}, 64'd1);
    drive(3'd1, 64'h22, 64'h0, 4'd2);
    tick();
    chk("bp2 i_ready", {63'd0, rdy32}, 64'd0);
    chk("bp2 itag", {60'd0, tag32}, 64'd1);
    drive(3'd1, 64'h33, 64'h0, 4'd3);
    for (int s = 0; s < 2; s++) begin
      tick();
      chk($sformatf("bp stall%0d i_ready", s), {63'd0, rdy64}, 64'd0);
      chk($sformatf("bp stall%0d o_valid", s), {63'd0, vld32}, 64'd1);
      chk($sformatf("bp stall%0d itag", s), {60'd0, tag32}, 64'd1);
      chk($sformatf("bp stall%0d data", s), {32'd0, d32}, 64'h11);
    end
    o_ready = 1'b1;
    tick();
    chk("bp pop1 itag", {60'd0, tag32}, 64'd2);
    chk("bp pop1 data", {32'd0, d32}, 64'h22);
    chk("bp pop1 i_ready", {63'd0, rdy32}, 64'd1);
    tick();
    i_valid = 1'b0;
    chk("bp pop2 itag", {60'd0, tag32}, 64'd3);
    chk("bp pop2 data64", d64, 64'hFFFF_FFFF_0000_0033);
    tick();
    chk("bp empty", {63'd0, vld32}, 64'd0);

    // Flush with two entries buffered and a concurrent input
    o_ready = 1'b0;
    drive(3'd1, 64'h66, 64'h0, 4'd6);
    tick();
    drive(3'd1, 64'h77, 64'h0, 4'd7);
    tick();
    chk("fl full i_ready", {63'd0, rdy32}, 64'd0);
    drive(3'd1, 64'h88, 64'h0, 4'd8);
    i_flush = 1'b1;
    o_ready = 1'b1;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("fl o_valid32", {63'd0, vld32}, 64'd0);
    chk("fl o_valid64", {63'd0, vld64}, 64'd0);
    chk("fl i_ready", {63'd0, rdy64}, 64'd1);
    tick();
    chk("fl dropped", {63'd0, vld32}, 64'd0);
    drive(3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5);
    tick();
    i_valid = 1'b0;
    chk("rsv o_valid", {63'd0, vld64}, 64'd1);
    chk("rsv data32", {32'd0, d32}, 64'd0);
    chk("rsv data64", d64, 64'd0);
    chk("rsv ill", {63'd0, ill32}, 64'd1);
    chk("rsv ifp", {63'd0, ifp64}, 64'd0);
    chk("rsv itag", {60'd0, tag64}, 64'd5);
    tick();

    // Asynchronous reset between edges
    o_ready = 1'b0;
    drive(3'd1, 64'h1234_5678, 64'h0, 4'd4);
    tick();
    i_valid = 1'b0;
    chk("ar pre o_valid", {63'd0, vld64}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar o_valid", {63'd0, vld64}, 64'd0);
    chk("ar data64", d64, 64'd0);
    chk("ar data32", {32'd0, d32}, 64'd0);
    chk("ar ifp", {63'd0, ifp64}, 64'd0);
    chk("ar itag", {60'd0, tag64}, 64'd0);
    chk("ar ill", {63'd0, ill64}, 64'd0);
    chk("ar i_ready", {63'd0, rdy64}, 64'd1);
    #2;
    rst_n = 1'b1;
    tick();
    chk("ar post o_valid", {63'd0, vld32}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e203_exu_fpu_fmis_mvsgn.md
# e203_exu_fpu_fmis_mvsgn

Parametrised FPU move and sign-injection unit in the E203 EXU FPU misc path. It executes FMV.X.W, FMV.W.X, FSGNJ.S, FSGNJN.S and FSGNJX.S with NaN-boxing support for FLEN of 32 or 64. Results are written through a registered two-entry skid buffer, so a stalled writeback port does not combinationally block the issue handshake. The unit sits between the FPU misc dispatcher and the FPU/integer writeback arbiter.

## Interface
- FLEN, 32, FP register width; legal values are 32 and 64.
- ITAG_W, 4, width of the instruction tag carried alongside each operation.
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  issue request valid.
- i_ready  output  1  issue ready; equals (count != 2).
- i_op  input  3  operation: 0 FMV_X_W, 1 FMV_W_X, 2 FSGNJ, 3 FSGNJN, 4 FSGNJX, 5–7 reserved.
- i_rs1  input  FLEN  operand 1 (FP register, or integer register for FMV_W_X).
- i_rs2  input  FLEN  operand 2; used by the sign-injection ops only.
- i_itag  input  ITAG_W  tag, returned unchanged with the result.
- i_flush  input  1  pipeline flush.
- o_valid  output  1  result valid.
- o_ready  input  1  writeback ready.
- o_wbck_wdat  output  FLEN  result data.
- o_wbck_ifp  output  1  1 = write the FP register file, 0 = write the integer register file.
- o_itag  output  ITAG_W  tag of the result.
- o_ill  output  1  result came from a reserved op.

## Operation
- **Unbox function u(x):**
  - FLEN=32: u(x) = x.
  - FLEN=64: u(x) = x[31:0] if x[63:32] == all ones; otherwise the canonical NaN 32'h7FC0_0000.
- **Box function b(r):** {(FLEN-32) ones, r}. For FLEN=32 it is the identity.
- **Per-op results:**
  - FMV_X_W: data = sign-extension of i_rs1[31:0] to FLEN, with no unbox check; ifp=0.
  - FMV_W_X: data = b(i_rs1[31:0]); ifp=1.
  - FSGNJ: data = b({u(rs2)[31], u(rs1)[30:0]}); ifp=1.
  - FSGNJN: data = b({~u(rs2)[31], u(rs1)[30:0]}); ifp=1.
  - FSGNJX: data = b({u(rs1)[31]^u(rs2)[31], u(rs1)[30:0]}); ifp=1.
  - Reserved ops: data = 0, ifp=0, ill=1. The op is still accepted and its tag is returned.
- **Buffer:** two-entry FIFO of {data, ifp, ill, itag}, with a 2-bit count (0..2), a 1-bit read pointer and a 1-bit write pointer.
  - Push when i_valid & i_ready & !i_flush.
  - Pop when o_valid & o_ready.
  - o_valid = (count != 0). Outputs drive the head entry directly from flops; there is no combinational path from i_* to o_*.
  - count=1 with push and pop in the same cycle: count stays 1 and the pointers advance.
  - count=2: i_ready=0, so a push is impossible; a pop makes i_ready=1 in the next cycle.
  - count=0: no pop. An input accepted in cycle N appears in cycle N+1 (no bypass).
- **Flush:** i_flush=1 clears count and both pointers at the clock edge.
  - An input presented in the same cycle is dropped.
  - A pop in the same cycle still completes.
  - o_valid=0 in the following cycle.
- **Output stability:** while o_valid & !o_ready and no flush, all o_* hold stable.

## Timing
- Latency is 1 cycle from acceptance to o_valid.
- Sustained throughput is 1 op/cycle while o_ready=1.
- With o_ready low, the unit absorbs 2 ops and then deasserts i_ready.
- i_ready depends only on count, never on o_ready in the same cycle.
- **Reset (asynchronous, takes effect immediately):**
  - count=0, pointers=0, all storage=0.
  - Outputs: o_valid=0, o_wbck_wdat=0, o_wbck_ifp=0, o_itag=0, o_ill=0, i_ready=1.
  - Reset asserted mid-operation discards all buffered results.
- Release of rst_n is synchronised externally. The first acceptance is possible on the first edge after release.

## Test plan
- **FMV_X_W, FLEN=32:** i_op=0, rs1=32'h8000_0001, o_ready=1 -> next cycle o_valid=1, data=32'h8000_0001, ifp=0.
- **FMV_W_X and unboxing, FLEN=64:**
  - FMV_W_X with rs1=64'h0000_0000_3F80_0000 -> data=64'hFFFF_FFFF_3F80_0000, ifp=1.
  - FSGNJ with rs1=64'h0000_0000_3F80_0000 (not boxed) and rs2 boxed 32'h8000_0000 -> data=64'hFFFF_FFFF_FFC0_0000.
- **Sign-injection, FLEN=32:** rs1=32'hBF80_0000, rs2=32'h8000_0000.
  - FSGNJ -> 32'hBF80_0000.
  - FSGNJN -> 32'h3F80_0000.
  - FSGNJX -> 32'h3F80_0000.
- **Backpressure:**
  - Hold o_ready=0 and issue 3 back-to-back ops with tags 1, 2, 3 -> tags 1 and 2 are accepted, then i_ready=0 and tag 3 is held.
  - Raise o_ready -> tags drain in order 1, 2, 3 on consecutive cycles with no loss or duplication, and outputs stay stable while stalled.
- **Flush and reserved op:**
  - With 2 entries buffered, pulse i_flush alongside i_valid -> next cycle o_valid=0, count=0, and the concurrent input is dropped.
  - Then i_op=6 with tag 5 -> data=0, ill=1, itag=5.
- **Asynchronous reset:** assert rst_n=0 mid-stream between clock edges -> o_valid drops immediately and all outputs read 0 before the next edge.
